wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter.sv | 113 +++++++++++
 tb/tb_wb_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the register file's single write port between the in-order pipeline
// writeback and a long-latency unit (load/mul/div return path). It also keeps
// a scoreboard of registers that are waiting for a long-latency result, so ID
// can stall on RAW hazards.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   pipe_valid/_rd_addr/_rd_data   pipeline writeback request
//   pipe_hold                pipeline write refused this cycle (WB holds)
//   lu_valid/_rd_addr/_rd_data     long-unit result, lu_ready accepts it
//   lu_issue/_issue_addr     long op issued by ID (sets scoreboard bit)
//   rs1_addr/rs2_addr        ID source addresses -> rs1_busy/rs2_busy
//   regwrite/rd_addr/rd_data registered register-file write port
module wb_port_arbiter #(
   parameter int REG_NUM    = 32,
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_valid,
   input  logic [ADDR_W-1:0] pipe_rd_addr,
   input  logic [DATA_W-1:0] pipe_rd_data,
   output logic              pipe_hold,
   input  logic              lu_valid,
   output logic              lu_ready,
   input  logic [ADDR_W-1:0] lu_rd_addr,
   input  logic [DATA_W-1:0] lu_rd_data,
   input  logic              lu_issue,
   input  logic [ADDR_W-1:0] lu_issue_addr,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              regwrite,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [3:0]         starve_cnt_reg;
   logic [3:0]         starve_cnt_next;
   logic [REG_NUM-1:0] busy_reg;
   logic [REG_NUM-1:0] busy_next;
   logic               force_lu;
   logic               pipe_acc;
   logic               lu_acc;

   // The pipeline normally wins; once the long unit has been refused
   // STARVE_MAX cycles in a row it takes the port for one cycle.
   assign force_lu  = lu_valid && (starve_cnt_reg == 4'(STARVE_MAX));
   assign lu_ready  = !pipe_valid || force_lu;
   assign pipe_hold = force_lu && pipe_valid;
   assign pipe_acc  = pipe_valid && !pipe_hold;
   assign lu_acc    = lu_valid && lu_ready;

   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!lu_valid || lu_acc)
         starve_cnt_next = 4'd0;
      else if (starve_cnt_reg != 4'(STARVE_MAX))
         starve_cnt_next = starve_cnt_reg + 4'd1;
   end

   // Scoreboard: x0 is never busy. Within a bit, an issue to the same
   // address as a retiring result wins, because the new op is younger.
   assign busy_next[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_busy
         assign busy_next[gi] =
            (lu_issue && (lu_issue_addr == ADDR_W'(gi))) ||
            (busy_reg[gi] && !(lu_acc && (lu_rd_addr == ADDR_W'(gi))));
      end
   endgenerate

   // Busy flags come from current state, so the acceptance cycle still
   // reports busy; the register file forwards the data the cycle after.
   assign rs1_busy = busy_reg[rs1_addr];
   assign rs2_busy = busy_reg[rs2_addr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_reg <= 4'd0;
         busy_reg       <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
         busy_reg       <= busy_next;
      end
   end

   // Output register. A write to x0 consumes the handshake without
   // asserting regwrite; address/data hold when nothing is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regwrite <= 1'b0;
         rd_addr  <= '0;
         rd_data  <= '0;
      end else if (lu_acc) begin
         regwrite <= (lu_rd_addr != '0);
         rd_addr  <= lu_rd_addr;
         rd_data  <= lu_rd_data;
      end else if (pipe_acc) begin
         regwrite <= (pipe_rd_addr != '0);
         rd_addr  <= pipe_rd_addr;
         rd_data  <= pipe_rd_data;
      end else begin
         regwrite <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model of the port rules.
module tb_wb_port_arbiter;
   localparam int REG_NUM    = 32;
   localparam int ADDR_W     = 5;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              pipe_valid;
   logic [ADDR_W-1:0] pipe_rd_addr;
   logic [DATA_W-1:0] pipe_rd_data;
   logic              pipe_hold;
   logic              lu_valid;
   logic              lu_ready;
   logic [ADDR_W-1:0] lu_rd_addr;
   logic [DATA_W-1:0] lu_rd_data;
   logic              lu_issue;
   logic [ADDR_W-1:0] lu_issue_addr;
   logic [ADDR_W-1:0] rs1_addr;
   logic [ADDR_W-1:0] rs2_addr;
   logic              rs1_busy;
   logic              rs2_busy;
   logic              regwrite;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   wb_port_arbiter #(
      .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .pipe_valid(pipe_valid), .pipe_rd_addr(pipe_rd_addr), .pipe_rd_data(pipe_rd_data),
      .pipe_hold(pipe_hold),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd_addr(lu_rd_addr), .lu_rd_data(lu_rd_data),
      .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .regwrite(regwrite), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Owner of the port each cycle; "refused" counts consecutive cycles the
   // long unit waited while presenting a result.
   typedef enum {G_NONE, G_PIPE, G_LU} grant_t;
   int          m_refused;
   bit          m_busy[REG_NUM];
   bit          m_we;
   int          m_addr;
   logic [31:0] m_data;
   grant_t      last_grant;

   function automatic grant_t who_wins();
      if (lu_valid && m_refused >= STARVE_MAX) return G_LU;
      if (pipe_valid) return G_PIPE;
      if (lu_valid) return G_LU;
      return G_NONE;
   endfunction

   task automatic model_reset();
      m_refused = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_we = 1'b0; m_addr = 0; m_data = '0;
      last_grant = G_NONE;
   endtask

   // One clock cycle with the currently driven inputs.
   task automatic step();
      grant_t g;
      bit     exp_ready;
      #1;
      g = who_wins();
      exp_ready = lu_valid ? (g == G_LU) : !pipe_valid;
      chk("lu_ready", lu_ready, exp_ready);
      chk("pipe_hold", pipe_hold, pipe_valid && g != G_PIPE);
      chk("rs1_busy", rs1_busy, m_busy[rs1_addr]);
      chk("rs2_busy", rs2_busy, m_busy[rs2_addr]);
      // model update from inputs seen at this edge
      if (lu_valid && g != G_LU) m_refused = (m_refused + 1 > STARVE_MAX) ? STARVE_MAX : m_refused + 1;
      else m_refused = 0;
      if (g == G_LU) m_busy[lu_rd_addr] = 1'b0;
      if (lu_issue && lu_issue_addr != 0) m_busy[lu_issue_addr] = 1'b1;
      if (g == G_LU) begin
         m_we = (lu_rd_addr != 0); m_addr = lu_rd_addr; m_data = lu_rd_data;
      end else if (g == G_PIPE) begin
         m_we = (pipe_rd_addr != 0); m_addr = pipe_rd_addr; m_data = pipe_rd_data;
      end else begin
         m_we = 1'b0;
      end
      last_grant = g;
      @(posedge clk);
      #1;
      chk("regwrite", regwrite, m_we);
      chk("rd_addr", rd_addr, m_addr);
      chk("rd_data", rd_data, m_data);
      $display("cyc t=%0t grant=%s we=%0d addr=%0d data=0x%0h", $time, g.name(), regwrite, rd_addr, rd_data);
   endtask

   task automatic drive(input bit pv, input int pa, input logic [31:0] pd,
                        input bit lv, input int la, input logic [31:0] ld,
                        input bit iss, input int ia, input int r1, input int r2);
      pipe_valid = pv; pipe_rd_addr = ADDR_W'(pa); pipe_rd_data = pd;
      lu_valid = lv; lu_rd_addr = ADDR_W'(la); lu_rd_data = ld;
      lu_issue = iss; lu_issue_addr = ADDR_W'(ia);
      rs1_addr = ADDR_W'(r1); rs2_addr = ADDR_W'(r2);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_regwrite"}, regwrite, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_rd_data"}, rd_data, 0);
      chk({tag, "_pipe_hold"}, pipe_hold, 0);
      chk({tag, "_rs1_busy"}, rs1_busy, 0);
   endtask

   initial begin
      model_reset();
      rst = 1'b1;
      drive(1, 5, 32'h55, 1, 6, 32'h66, 0, 0, 6, 6);
      #2;
      reset_checks("rst");
      repeat (2) @(posedge clk);
      #1;
      reset_checks("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      // first write after reset: pipe wins, lu refused
      drive(1, 5, 32'h55, 1, 6, 32'h66, 0, 0, 0, 0);
      step();
      chk("post_rst_wr", rd_addr, 5);
      drive(0, 5, 32'h55, 1, 6, 32'h66, 0, 0, 0, 0);
      step();
      chk("post_rst_lu", rd_addr, 6);
      idle();

      // pipeline only
      drive(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("pipe_we", regwrite, 1);
      chk("pipe_data", rd_data, 32'h1234);
      drive(1, 0, 32'hdead, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("pipe_x0_we", regwrite, 0);

      // conflict
      drive(1, 3, 32'hA, 1, 7, 32'hB, 0, 0, 0, 0);
      step();
      chk("conf_addr_n1", rd_addr, 3);
      drive(0, 0, 0, 1, 7, 32'hB, 0, 0, 0, 0);
      #1 chk("conf_ready_n1", lu_ready, 1);
      step();
      chk("conf_data_n2", rd_data, 32'hB);
      idle();

      // starvation
      for (int c = 0; c < 6; c++) begin
         if (c == 4 || c == 5) drive(1, 20, 32'h400, 1, 21, 32'h21, 0, 0, 0, 0);
         else drive(1, 10 + c, 32'h100 + c, 1, 21, 32'h21, 0, 0, 0, 0);
         if (c == 5) lu_valid = 1'b0;
         #1;
         if (c < 4) chk("starve_ready", lu_ready, 0);
         if (c == 4) chk("starve_hold", pipe_hold, 1);
         if (c == 5) chk("starve_hold_clr", pipe_hold, 0);
         step();
         if (c == 4) chk("starve_lu_wr", rd_addr, 21);
         if (c == 5) chk("starve_pipe_wr", rd_data, 32'h400);
      end
      idle();

      // scoreboard: issue 9, then x0 issue, then retire 9
      drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 9, 0);
      #1 chk("sb_busy9", rs1_busy, 1);
      step();
      chk("sb_x0_never", dut.rs2_busy, 0);
      drive(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
      #1 chk("sb_busy_acc_cycle", rs1_busy, 1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
      #1 chk("sb_clear_after", rs1_busy, 0);
      step();

      // simultaneous set/clear on r12
      drive(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
      step();
      drive(0, 0, 0, 1, 12, 32'hC12, 1, 12, 12, 0);
      step();
      chk("simul_write", rd_addr, 12);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
      #1 chk("simul_busy_kept", rs1_busy, 1);
      step();
      drive(0, 0, 0, 1, 12, 32'hC13, 0, 0, 12, 0);
      step();
      idle();

      // randomized traffic obeying both hold-stable rules
      for (int n = 0; n < 400; n++) begin
         if (!lu_valid || last_grant == G_LU) begin
            lu_valid   = ($urandom_range(0, 1) == 1);
            lu_rd_addr = ADDR_W'($urandom_range(0, 7));
            lu_rd_data = $urandom;
         end
         if (!pipe_valid || last_grant == G_PIPE) begin
            pipe_valid   = ($urandom_range(0, 3) != 0);
            pipe_rd_addr = ADDR_W'($urandom_range(0, REG_NUM - 1));
            pipe_rd_data = $urandom;
         end
         lu_issue      = ($urandom_range(0, 2) == 0);
         lu_issue_addr = ADDR_W'($urandom_range(0, 7));
         rs1_addr      = ADDR_W'($urandom_range(0, 7));
         rs2_addr      = ADDR_W'($urandom_range(0, REG_NUM - 1));
         step();
      end

      // reset mid-operation clears everything at once
      drive(1, 4, 32'h44, 1, 5, 32'h55, 1, 6, 6, 5);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      reset_checks("midrst");
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 1, 5, 32'h55, 0, 0, 6, 5);
      step();
      chk("midrst_lu_again", rd_data, 32'h55);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
